cla_nibble_serial_addsub: RTL
=============================

// Module: cla_nibble_serial_addsub
// PURPOSE
//   Multi-cycle WIDTH-bit adder/subtractor built on one cla_fourbit_trial1 instance.
//   Processes one 4-bit nibble per clock, LSB first, with carry held in a register between nibbles.
//   It is the synthesizable datapath consumer of the 4-bit CLA: it drives the same a/b/cin/sum/cout slice.
//   Start/busy/done handshake; results stay held until the next accepted start.
// PARAMETERS
//   WIDTH   16   operand width in bits; must be a multiple of 4 and >= 8
// PORTS
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      request; sampled only in IDLE
//   sub     in   1      0: add, 1: subtract (latched with start)
//   a       in   WIDTH  operand A (latched with start)
//   b       in   WIDTH  operand B (latched with start)
//   cin     in   1      carry-in (add) / borrow-in (sub), latched with start
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse: result valid
//   sum     out  WIDTH  result
//   cout    out  1      raw carry out of MSB (sub: 1 = no borrow)
//   ovf     out  1      two's-complement signed overflow
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, nibble counter=0, carry reg=0.
//     Outputs: busy=0, done=0, sum=0, cout=0, ovf=0. Reset mid-RUN aborts the operation; no done is produced.
//   - Operand conditioning at accept:
//     - add: A=a, B=b, C=cin.
//     - sub: A=a, B=~b, C=~cin, so the result is a-b-cin mod 2^WIDTH.
//   - FSM:
//     - IDLE: start=1 -> latch A/B/C/sub, counter=0, go to RUN. Otherwise stay in IDLE.
//     - RUN: each edge, nibble i=counter is processed: CLA(A[4i+3:4i], B[4i+3:4i], carry) -> sum[4i+3:4i].
//       The CLA cout is written to the carry reg and counter increments.
//       After the last nibble (i=WIDTH/4-1): cout=CLA cout, ovf computed, go to DONE.
//     - DONE: done=1 for exactly this cycle, then IDLE on the next edge.
//   - Latency: done is high in the cycle after the (WIDTH/4)-th rising edge following the start-sampling edge.
//     For WIDTH=16 that is 4 edges. Throughput is one op per WIDTH/4+2 cycles.
//   - busy=1 only in RUN. start is ignored in RUN and DONE; there is no queueing.
//   - sum is written nibble-by-nibble during RUN. Intermediate values are not guaranteed.
//     sum, cout and ovf are stable from done and held through IDLE until the next accepted start.
//   - ovf = (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]), where B is the conditioned operand (~b for sub).
//   - Wrap-around: results are modulo 2^WIDTH. Carry out of the MSB appears only on cout.
//   - Operand inputs may change freely after the accept edge without affecting the result.
// TESTING (WIDTH=16; check sum/cout/ovf when done=1)
//   1. add 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0.
//      done exactly 4 edges after start; busy high for 4 cycles.
//   2. add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all nibble registers).
//      add 0xFFFF+0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
//   3. add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
//   4. sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0 (borrow), ovf=0.
//      sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
//      sub 0x0010-0x0001, cin=1 -> sum=0x000E, cout=1.
//   5. Handshake: pulse start with new operands during RUN and again during DONE -> both are ignored and the
//      first result is unchanged. Change a/b after accept -> no effect on the result.
//   6. Reset: assert rst mid-RUN -> all outputs 0 immediately (async), no done pulse.
//      A start after reset release completes normally.
//      Random sweep: 1000 ops with random a/b/cin/sub checked against a behavioural model.

Source files
------------

// File: rtl/cla_nibble_serial_addsub_if.sv
// ---------------------------------------------------------------------------
// cla_nibble_serial_addsub_if
//   Request/result bundle for the nibble-serial adder/subtractor.
//   master: drives start/sub/a/b/cin and observes busy/done/sum/cout/ovf.
//   slave : the arithmetic unit (the reverse directions).
//   Signals:
//     start  request (sampled only while the unit is idle)
//     sub    0 = add, 1 = subtract
//     a, b   WIDTH-bit operands
//     cin    carry-in (add) / borrow-in (sub)
//     busy   high while nibbles are being processed
//     done   one-cycle pulse, result valid
//     sum    WIDTH-bit result
//     cout   raw carry out of the MSB (sub: 1 = no borrow)
//     ovf    two's-complement signed overflow
// ---------------------------------------------------------------------------
interface cla_nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/cla_nibble_serial_addsub.sv
// ---------------------------------------------------------------------------
// cla_fourbit_trial1
//   Combinational 4-bit carry-lookahead adder.
//   Ports: a, b (4-bit operands), cin (carry in), sum (4-bit), cout (carry out)
//
// cla_nibble_serial_addsub
//   Multi-cycle WIDTH-bit adder/subtractor that pushes one nibble per clock
//   (LSB first) through a single cla_fourbit_trial1, keeping the inter-nibble
//   carry in a register. Start/busy/done handshake; the result is held until
//   the next accepted start.
//   Ports: clk (rising edge), rst (asynchronous, active high),
//          bus (slave side of cla_nibble_serial_addsub_if)
// ---------------------------------------------------------------------------
module cla_fourbit_trial1 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p/cin: no ripple path.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    cla_nibble_serial_addsub_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg;      // conditioned operand A
    logic [WIDTH-1:0] b_reg;      // conditioned operand B (~b for subtract)
    logic             carry_reg;  // carry into the nibble being processed
    logic [CW-1:0]    cnt_reg;    // index of the nibble being processed
    logic             cout_reg;
    logic             ovf_reg;

    logic       accept;
    logic       running;
    logic       last_nib;
    logic [3:0] a_nib [NIB];
    logic [3:0] b_nib [NIB];
    logic [3:0] sum_nib [NIB];
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_sum;
    logic       nib_cout;
    logic [WIDTH-1:0] sum_vec;

    assign accept   = (state_reg == IDLE) && bus.start;
    assign running  = (state_reg == RUN);
    assign last_nib = (cnt_reg == CW'(NIB - 1));

    // Per-nibble operand slices and per-nibble result registers.
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        logic [3:0] sum_q;

        assign a_nib[gi]   = a_reg[4*gi +: 4];
        assign b_nib[gi]   = b_reg[4*gi +: 4];
        assign sum_nib[gi] = sum_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
            end else if (running && (cnt_reg == CW'(gi))) begin
                sum_q <= nib_sum;
            end
        end
    end

    always_comb begin
        sum_vec = '0;
        for (int i = 0; i < NIB; i++) begin
            sum_vec[4*i +: 4] = sum_nib[i];
        end
    end

    assign nib_a = a_nib[cnt_reg];
    assign nib_b = b_nib[cnt_reg];

    cla_fourbit_trial1 u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_reg),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_next = state_reg;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and nibble datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + ~cin, i.e. a - b - cin modulo 2^WIDTH.
            a_reg     <= bus.a;
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.sub ? ~bus.cin : bus.cin;
            cnt_reg   <= '0;
        end else if (running) begin
            carry_reg <= nib_cout;
            cnt_reg   <= cnt_reg + 1'b1;
            if (last_nib) begin
                cout_reg <= nib_cout;
                // nib_sum[3] is the result MSB on the final nibble.
                ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                         && (nib_sum[3] != a_reg[WIDTH-1]);
            end
        end
    end

    assign bus.sum  = sum_vec;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule
